// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle. The pipeline drives the master side and the controller is the slave side.
// The perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
    logic [4:0] i_addr_Drs;
    logic [4:0] i_addr_Drt;
    logic [4:0] i_addr_Ert;
    logic       i_con_Ememread;
    logic       i_con_Dbranch_taken;
    logic       i_con_Djump;
    logic       i_con_Emuldiv_start;
    logic       i_con_Emuldiv_div;
    logic       i_con_Dmuldiv_use;
    logic       o_con_Fstall;
    logic       o_con_Dstall;
    logic       o_con_Eflush;
    logic       o_con_Dflush;
    logic       o_con_muldiv_busy;
    logic       o_con_muldiv_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] o_data_stallcnt;
    logic [31:0] o_data_flushcnt;
`endif

    modport master (
        output i_addr_Drs, i_addr_Drt, i_addr_Ert, i_con_Ememread,
               i_con_Dbranch_taken, i_con_Djump, i_con_Emuldiv_start,
               i_con_Emuldiv_div, i_con_Dmuldiv_use,
`ifdef HAZARD_PERF_EN
        input  o_data_stallcnt, o_data_flushcnt,
`endif
        input  o_con_Fstall, o_con_Dstall, o_con_Eflush, o_con_Dflush,
               o_con_muldiv_busy, o_con_muldiv_done
    );

    modport slave (
        input  i_addr_Drs, i_addr_Drt, i_addr_Ert, i_con_Ememread,
               i_con_Dbranch_taken, i_con_Djump, i_con_Emuldiv_start,
               i_con_Emuldiv_div, i_con_Dmuldiv_use,
`ifdef HAZARD_PERF_EN
        output o_data_stallcnt, o_data_flushcnt,
`endif
        output o_con_Fstall, o_con_Dstall, o_con_Eflush, o_con_Dflush,
               o_con_muldiv_busy, o_con_muldiv_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch-flush hazard unit with a multi-cycle mult/div sequencer.
// Define HAZARD_PERF_EN to add saturating stall and flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

    // Loaded with cycles-2: one cycle is spent entering BUSY and one in DONE.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lu, md, stall, dflush;

    always_comb begin
        lu = hz.i_con_Ememread && (hz.i_addr_Ert != 5'd0) &&
             ((hz.i_addr_Ert == hz.i_addr_Drs) || (hz.i_addr_Ert == hz.i_addr_Drt));
        md     = busy_q & hz.i_con_Dmuldiv_use;
        // Gated by reset so combinational outputs are also held low during reset.
        stall  = i_nrst & (lu | md);
        dflush = i_nrst & (hz.i_con_Dbranch_taken | hz.i_con_Djump) & ~stall;
    end

    assign hz.o_con_Fstall      = stall;
    assign hz.o_con_Dstall      = stall;
    assign hz.o_con_Eflush      = stall;
    assign hz.o_con_Dflush      = dflush;
    assign hz.o_con_muldiv_busy = busy_q;
    assign hz.o_con_muldiv_done = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hz.i_con_Emuldiv_start) begin
                    state_d = BUSY;
                    cnt_d   = hz.i_con_Emuldiv_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                if (hz.i_con_Emuldiv_start) begin
                    state_d = BUSY;
                    cnt_d   = hz.i_con_Emuldiv_div ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallcnt_q, stallcnt_d;
    logic [31:0] flushcnt_q, flushcnt_d;

    always_comb begin
        stallcnt_d = stallcnt_q;
        flushcnt_d = flushcnt_q;
        if (stall  && (stallcnt_q != 32'hFFFF_FFFF)) stallcnt_d = stallcnt_q + 32'd1;
        if (dflush && (flushcnt_q != 32'hFFFF_FFFF)) flushcnt_d = flushcnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stallcnt_q <= '0;
            flushcnt_q <= '0;
        end else begin
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    assign hz.o_data_stallcnt = stallcnt_q;
    assign hz.o_data_flushcnt = flushcnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle hazard checks plus a done-pulse scoreboard.
module tb_pipe_hazard_ctrl;
    localparam int MULC = 4;
    localparam int DIVC = 32;

    typedef struct {
        int start_cyc;
        int done_cyc;
    } md_op_t;

    logic clk;
    logic nrst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    md_op_t sb_q[$];
`ifdef HAZARD_PERF_EN
    int exp_stallcnt;
    int exp_flushcnt;
`endif

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .hz     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic model_busy();
        return (sb_q.size() > 0) && (cyc > sb_q[0].start_cyc) && (cyc < sb_q[0].done_cyc);
    endfunction

    task automatic check_all();
        logic lu_e, busy_e, stall_e, flush_e;
        lu_e = bus.i_con_Ememread && (bus.i_addr_Ert != 5'd0) &&
               (bus.i_addr_Ert == bus.i_addr_Drs || bus.i_addr_Ert == bus.i_addr_Drt);
        busy_e  = model_busy();
        stall_e = lu_e | (busy_e & bus.i_con_Dmuldiv_use);
        flush_e = (bus.i_con_Dbranch_taken | bus.i_con_Djump) & ~stall_e;
        check_eq("fstall", 32'(bus.o_con_Fstall), 32'(stall_e));
        check_eq("dstall", 32'(bus.o_con_Dstall), 32'(stall_e));
        check_eq("eflush", 32'(bus.o_con_Eflush), 32'(stall_e));
        check_eq("dflush", 32'(bus.o_con_Dflush), 32'(flush_e));
        check_eq("busy",   32'(bus.o_con_muldiv_busy), 32'(busy_e));
        if (sb_q.size() > 0 && cyc == sb_q[0].done_cyc) begin
            check_eq("done", 32'(bus.o_con_muldiv_done), 32'd1);
            void'(sb_q.pop_front());
        end else begin
            check_eq("done", 32'(bus.o_con_muldiv_done), 32'd0);
        end
        if (bus.i_con_Emuldiv_start && !model_busy() && sb_q.size() == 0) begin
            md_op_t op;
            op.start_cyc = cyc;
            op.done_cyc  = cyc + (bus.i_con_Emuldiv_div ? DIVC : MULC);
            sb_q.push_back(op);
        end
`ifdef HAZARD_PERF_EN
        check_eq("stallcnt", bus.o_data_stallcnt, 32'(exp_stallcnt));
        check_eq("flushcnt", bus.o_data_flushcnt, 32'(exp_flushcnt));
        if (stall_e) exp_stallcnt++;
        if (flush_e) exp_flushcnt++;
`endif
        $display("[TB] cyc=%0d lu=%0b use=%0b st=%0b stall=%0b dflush=%0b busy=%0b done=%0b",
                 cyc, lu_e, bus.i_con_Dmuldiv_use, bus.i_con_Emuldiv_start,
                 bus.o_con_Fstall, bus.o_con_Dflush, bus.o_con_muldiv_busy, bus.o_con_muldiv_done);
    endtask

    task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] drs,
                          input logic [4:0] drt, input logic br, input logic jmp,
                          input logic st, input logic dv, input logic use_hl);
        bus.i_con_Ememread      = mr;
        bus.i_addr_Ert          = ert;
        bus.i_addr_Drs          = drs;
        bus.i_addr_Drt          = drt;
        bus.i_con_Dbranch_taken = br;
        bus.i_con_Djump         = jmp;
        bus.i_con_Emuldiv_start = st;
        bus.i_con_Emuldiv_div   = dv;
        bus.i_con_Dmuldiv_use   = use_hl;
    endtask

    task automatic drv(input logic mr, input logic [4:0] ert, input logic [4:0] drs,
                       input logic [4:0] drt, input logic br, input logic jmp,
                       input logic st, input logic dv, input logic use_hl);
        @(negedge clk);
        set_in(mr, ert, drs, drt, br, jmp, st, dv, use_hl);
        #2;
        check_all();
    endtask

    task automatic idle(input int n, input logic use_hl);
        for (int i = 0; i < n; i++) drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, use_hl);
    endtask

    // Asserts reset asynchronously mid-cycle with a load-use pattern present, checks all outputs low.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        nrst = 1'b0;
        #1;
        check_eq({tag, "_fstall"}, 32'(bus.o_con_Fstall), 32'd0);
        check_eq({tag, "_dstall"}, 32'(bus.o_con_Dstall), 32'd0);
        check_eq({tag, "_eflush"}, 32'(bus.o_con_Eflush), 32'd0);
        check_eq({tag, "_dflush"}, 32'(bus.o_con_Dflush), 32'd0);
        check_eq({tag, "_busy"},   32'(bus.o_con_muldiv_busy), 32'd0);
        check_eq({tag, "_done"},   32'(bus.o_con_muldiv_done), 32'd0);
`ifdef HAZARD_PERF_EN
        check_eq({tag, "_stallcnt"}, bus.o_data_stallcnt, 32'd0);
        check_eq({tag, "_flushcnt"}, bus.o_data_flushcnt, 32'd0);
        exp_stallcnt = 0;
        exp_flushcnt = 0;
`endif
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nrst = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        nrst    = 1'b1;
`ifdef HAZARD_PERF_EN
        exp_stallcnt = 0;
        exp_flushcnt = 0;
`endif
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset("rst0");
        idle(2, 1'b0);

        // Load-use matches on rs, on rt, none, and the r0 exemption.
        drv(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 5'd9, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch held under stall, then flushed once the hazard clears.
        drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("br_stall_noflush", 32'(bus.o_con_Dflush), 32'd0);
        drv(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("br_release_flush", 32'(bus.o_con_Dflush), 32'd1);
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Multiply with a HI/LO consumer waiting.
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(MULC + 1, 1'b1);

        // Divide, with an ignored second start 5 cycles in and lu overlapping md.
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b0);
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(DIVC, 1'b1);

        // Back-to-back: a start in the DONE cycle restarts immediately.
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(MULC - 1, 1'b0);
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(MULC + 2, 1'b0);

        // Reset mid-divide: the in-flight op must produce no done pulse.
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(9, 1'b0);
        do_reset("rst_mid");
        idle(DIVC + 4, 1'b0);

`ifdef HAZARD_PERF_EN
        do_reset("rst_perf");
        idle(1, 1'b0);
        for (int i = 0; i < 3; i++) drv(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_eq("perf_stall3", bus.o_data_stallcnt, 32'd3);
        check_eq("perf_flush2", bus.o_data_flushcnt, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It detects load-use hazards between the decode and execute stages and inserts bubbles. It flushes the fetch/decode register on taken branches and jumps. It owns a multi-cycle multiply/divide sequencer and stalls HI/LO consumers until the result is ready. Outputs drive the fetch/decode register enables and the decode/execute bubble insertion.

Parameters:
MUL_CYCLES, 4, execute cycles for a multiply, >=2
DIV_CYCLES, 32, execute cycles for a divide, >=2
CNT_W, 6, muldiv counter width, must hold DIV_CYCLES-1

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_addr_Drs  in  5  rs of the instruction in decode
i_addr_Drt  in  5  rt of the instruction in decode
i_addr_Ert  in  5  rt (load destination) of the instruction in execute
i_con_Ememread  in  1  execute-stage instruction is a load
i_con_Dbranch_taken  in  1  branch resolved taken in decode
i_con_Djump  in  1  jump in decode
i_con_Emuldiv_start  in  1  execute-stage instruction starts mult/div
i_con_Emuldiv_div  in  1  1=divide, 0=multiply; valid with start
i_con_Dmuldiv_use  in  1  decode instruction reads HI/LO or starts mult/div
o_con_Fstall  out  1  hold PC
o_con_Dstall  out  1  hold fetch/decode register
o_con_Eflush  out  1  insert bubble into decode/execute register
o_con_Dflush  out  1  clear fetch/decode register
o_con_muldiv_busy  out  1  sequencer in BUSY
o_con_muldiv_done  out  1  one-cycle pulse when the result is valid

Behaviour:
- Reset: i_nrst=0 forces every output to 0, FSM to IDLE and the counter to 0, asynchronously. Reset mid-operation abandons any in-flight mult/div with no done pulse.
- Load-use (combinational, same cycle): lu = i_con_Ememread & (i_addr_Ert!=0) & (i_addr_Ert==i_addr_Drs | i_addr_Ert==i_addr_Drt).
- Muldiv FSM states: IDLE, BUSY, DONE.
  - IDLE with i_con_Emuldiv_start: go to BUSY. Load cnt = (div ? DIV_CYCLES : MUL_CYCLES) - 2.
  - BUSY: decrement cnt each cycle. When cnt==0, go to DONE next cycle.
  - DONE: o_con_muldiv_done=1 for exactly one cycle, then go to IDLE. A start in DONE goes directly to BUSY with a fresh count.
  - A start while in BUSY is ignored and leaves the state and count unchanged.
  - Latency: start in cycle N gives done high in cycle N+MUL_CYCLES (or N+DIV_CYCLES).
- o_con_muldiv_busy = (state==BUSY), registered.
- md = o_con_muldiv_busy & i_con_Dmuldiv_use. The consumer releases in the DONE cycle.
- stall = lu | md.
  - o_con_Fstall = o_con_Dstall = o_con_Eflush = stall.
- o_con_Dflush = (i_con_Dbranch_taken | i_con_Djump) & ~stall. Stall has priority because the branch is held and re-resolved next cycle.
- Simultaneous lu and md produce a single stall; no double counting.
- No counter wrap: cnt stops at 0 outside BUSY.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - Adds o_data_stallcnt (out, 32 bits), counting cycles with stall=1.
  - Adds o_data_flushcnt (out, 32 bits), counting cycles with o_con_Dflush=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: Ememread=1, Ert=5, Drs=5 -> Fstall=Dstall=Eflush=1 that cycle. Same with Ert=0 -> all 0.
- Multiply: start, div=0 at cycle 10 -> busy=1 for cycles 11-13, done=1 at cycle 14, busy=0 at cycle 14. Dmuldiv_use held high -> stall=1 in cycles 11-13 and 0 in cycle 14.
- Divide: start, div=1 -> done exactly 32 cycles later. A second start at +5 is ignored; done timing is unchanged.
- Branch under stall: Dbranch_taken=1 with lu=1 -> Dflush=0, stall=1. Next cycle lu=0 -> Dflush=1.
- Reset mid-divide: drop i_nrst at +10 -> all outputs 0 immediately. After release, busy=0 and no done pulse.
- HAZARD_PERF_EN: 3 load-use cycles plus 2 jumps -> stallcnt=3, flushcnt=2.
